spi_reg_master: RTL and testbench
=================================

# spi_reg_master

SPI initiator that shifts one fixed-length frame out on MOSI while capturing MISO, for driving on-board SPI peripherals (DAC, ADC) and for exercising the FPGA's own register-bank SPI responder in loopback. It is the initiator counterpart of the register-bank responder. The responder samples MOSI on the falling SCLK edge while CS is low, so this block uses SPI mode 1: idle-low SCLK, data launched on the rising edge and sampled on the falling edge, MSB first. It sits between the internal control logic, which uses a start/busy/done handshake, and the board pins.

## Interface
Parameters:
- FRAME_BITS, 16, bits per frame (address byte + value byte for register frames); legal range 2..32
- CLK_DIV, 2, `clk` cycles per SCLK half-period (H); legal range 1..255

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request to begin a frame; sampled only while busy=0
- tx_data  in  FRAME_BITS  frame to send; latched in the cycle start is accepted
- busy  out  1  high from the accept cycle to the end of the inter-frame gap
- done  out  1  one-cycle pulse when rx_data is valid
- rx_data  out  FRAME_BITS  MISO bits captured in the last frame, MSB first
- spi_cs_n  out  1  chip select, active low
- spi_clk  out  1  SCLK, idles low
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in; treated as synchronous to the SCLK the block generates

## Operation
- States:
  - IDLE -> SETUP: when start=1 and busy=0; tx_data is latched into the shift register.
  - SETUP: cs_n low, SCLK low, lasts H cycles -> SHIFT.
  - SHIFT: FRAME_BITS SCLK periods.
    - Each rising edge drives the next MSB onto MOSI.
    - Each falling edge shifts spi_miso into the receive register.
    - After the last falling edge -> HOLD.
  - HOLD: H cycles, SCLK low -> GAP. In the cycle cs_n rises, rx_data is updated and done pulses.
  - GAP: cs_n high for H cycles -> IDLE, busy=0.
- The block produces exactly FRAME_BITS falling edges per frame, never more or fewer. The responder relies on this count.
- start while busy=1 is ignored and not queued.
- start held high continuously produces back-to-back frames, each separated by the GAP.
- tx_data changes after the accept cycle have no effect on the frame in flight.
- spi_mosi holds its last driven bit in HOLD and GAP, and is 0 in IDLE.
- rx_data holds its value until the next done.

## Timing
- Reset values: spi_cs_n=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rx_data=0, state=IDLE. Reset is asynchronous.
- Reset mid-frame: cs_n rises and SCLK falls immediately. No done pulse. rx_data returns to 0.
- Cycle numbering: the start-accept cycle is 0, N=FRAME_BITS.
  - Cycle 1: cs_n falls and busy rises.
  - Bit k rising edge: cycle 1+H+2kH.
  - Bit k falling edge: cycle 1+2H+2kH.
  - Last falling edge: cycle 1+2NH.
  - cs_n rises and done pulses: cycle 1+(2N+1)H.
  - busy falls: cycle 1+(2N+2)H. The next start can be accepted in that same cycle.
- SCLK duty is exactly 50%.
- MOSI is stable from each rising edge through the following falling edge.
- All outputs are registered; no combinational path from input to output.

## Structure
- Shared package spi_pkg holds:
  - SPI_FRAME_BITS_DEFAULT = 16
  - mode constants CPOL=0, CPHA=1
  - state enum: IDLE, SETUP, SHIFT, HOLD, GAP
- Sub-module spi_tick_gen: a CLK_DIV half-period counter that emits a one-cycle tick. It is cleared when a frame is accepted and used by all timed states.
- Top of block: the FSM, the TX/RX shift registers, and a bit counter of width $clog2(FRAME_BITS+1).

## Test plan
- Basic frame: FRAME_BITS=16, CLK_DIV=2, tx_data=16'h0703, MISO looped to MOSI.
  - MOSI bits sampled on falling edges = 0000_0111_0000_0011.
  - rx_data=16'h0703.
  - cs_n low on cycles 1..66 and high at 67; done at 67; busy low at 69.
- Responder loopback: connect the register-bank responder (special=0).
  - Send 16'h0803 -> reg_mux=8'h03.
  - Send 16'h0902 -> reg_dac=4'h2.
  - Exactly 16 falling edges per cs_n-low window.
- Start while busy: pulse start with 16'h1234, then pulse start with 16'hFFFF at cycle 10.
  - Only one frame is sent, with value 16'h1234.
  - Exactly one done.
- Back-to-back: start held high, CLK_DIV=1.
  - Each cs_n-high gap is exactly 1 cycle plus the accept cycle.
  - Frame 2 carries tx_data as it was at its own accept cycle.
- Reset mid-frame: assert rst_n=0 during bit 5.
  - cs_n=1, spi_clk=0, busy=0 asynchronously.
  - No done pulse.
  - The next start gives a full, correct frame.
- Extremes: CLK_DIV=1 with FRAME_BITS=2, and CLK_DIV=255 with FRAME_BITS=32.
  - Edge counts and cycle positions match the Timing formulas.
  - MISO pattern 32'hA5A5_5A5A is captured exactly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame default, mode constants and the frame FSM states.
package spi_pkg;

  localparam int unsigned SPI_FRAME_BITS_DEFAULT = 16;

  // Mode 1: SCLK idles low, launch on the rising edge, sample on the falling edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b1;

  // SCLK level held just before the sampling edge (high for mode 1).
  localparam logic SAMPLE_LVL = CPOL ^ CPHA;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: tick_o is high for one cycle every CLK_DIV cycles.
// clr_i restarts the count so the first tick lands CLK_DIV cycles after the clear.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count; the tick is pre-computed so it is registered yet aligned with cnt_q == LAST.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_q) begin
      cnt_d = '0;
    end
    tick_d = (cnt_d == LAST);
  end

  // Counter and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= (LAST == '0);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-1 initiator: shifts one FRAME_BITS frame out on MOSI, MSB first,
// while capturing MISO on each falling SCLK edge.
module spi_reg_master
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_BITS = SPI_FRAME_BITS_DEFAULT,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int unsigned BC_W = $clog2(FRAME_BITS + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_BITS - 1);

  spi_state_e state_q, state_d;

  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
  logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;

  logic tick;
  logic accept_c;
  logic sample_edge_c;
  logic launch_edge_c;

  assign accept_c      = (state_q == IDLE) && start;
  assign sample_edge_c = (state_q == SHIFT) && tick && (sclk_q == SAMPLE_LVL);
  assign launch_edge_c = ((state_q == SETUP) && tick) ||
                         ((state_q == SHIFT) && tick && (sclk_q != SAMPLE_LVL));

  // Half-period timer, restarted on accept so SETUP always lasts exactly CLK_DIV cycles.
  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept_c),
    .tick_o (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; SHIFT ends on the falling edge of the last bit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (sample_edge_c && (bit_cnt_q == LAST_BIT)) state_d = HOLD;
      HOLD:    if (tick) state_d = GAP;
      GAP:     if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; every pin change is registered below.
  always_comb begin
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;

    if (accept_c) begin
      cs_n_d    = 1'b0;
      busy_d    = 1'b1;
      tx_sr_d   = tx_data;
      rx_sr_d   = '0;
      bit_cnt_d = '0;
    end

    // Launch edge: SCLK rises and the next MSB goes onto MOSI.
    if (launch_edge_c) begin
      sclk_d  = ~CPOL;
      mosi_d  = tx_sr_q[FRAME_BITS-1];
      tx_sr_d = tx_sr_q << 1;
    end

    // Sample edge: SCLK falls and MISO enters the receive register.
    if (sample_edge_c) begin
      sclk_d    = CPOL;
      rx_sr_d   = {rx_sr_q[FRAME_BITS-2:0], spi_miso};
      bit_cnt_d = bit_cnt_q + BC_W'(1);
    end

    // End of HOLD: release CS and publish the captured frame.
    if ((state_q == HOLD) && tick) begin
      cs_n_d    = 1'b1;
      done_d    = 1'b1;
      rx_data_d = rx_sr_q;
    end

    // End of GAP: back to idle with MOSI parked low.
    if ((state_q == GAP) && tick) begin
      busy_d = 1'b0;
      mosi_d = 1'b0;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_q    <= 1'b1;
      sclk_q    <= CPOL;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign spi_cs_n = cs_n_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Scoreboard bench for spi_reg_master at three parameter points:
// 16/2 (default), 2/1 (shortest) and 32/255 (longest).
module tb_spi_reg_master;

  typedef struct {
    logic [31:0] tx;
    logic [31:0] pat;
    int unsigned acc;
    bit          b2b;
  } exp_t;

  localparam logic [31:0] D16 [3] = '{32'h0703, 32'h0803, 32'h0902};

  logic        clk = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  // Edge positions relative to the accept cycle.
  function automatic int unsigned t_rise(input int unsigned acc, input int unsigned k,
                                         input int unsigned h);
    return acc + 1 + h + 2 * k * h;
  endfunction

  function automatic int unsigned t_fall(input int unsigned acc, input int unsigned k,
                                         input int unsigned h);
    return acc + 1 + 2 * h + 2 * k * h;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int unsigned N     = (g == 0) ? 16 : (g == 1) ? 2 : 32;
    localparam int unsigned H     = (g == 0) ? 2 : (g == 1) ? 1 : 255;
    localparam int unsigned NDIR  = (H > 10) ? 1 : 3;
    localparam int unsigned NBUSY = (H > 10) ? 0 : 1;
    localparam int unsigned NRND  = (H > 10) ? 0 : 4;
    localparam int unsigned NB2B  = (H > 10) ? 0 : 3;
    localparam int unsigned BOFF  = (2 * N * H > 10) ? 10 : 3;
    localparam int unsigned RB    = (N > 5) ? 5 : N - 1;
    localparam int unsigned TMO   = (2 * N + 4) * H + 20;
    localparam logic [31:0] MASK  = (N == 32) ? 32'hFFFF_FFFF : ((32'd1 << N) - 32'd1);

    logic          rst_n, start, busy, done, cs_n, sclk, mosi, miso;
    logic [N-1:0]  tx_data, rx_data;
    exp_t          q[$];
    bit            fin = 1'b0;

    logic          p_cs, p_sclk, p_busy, p_mosi, busy_exp;
    int unsigned   fall_cnt, rise_cnt, edge_err, stray, last_acc, cs_rise_cyc;
    logic [31:0]   mosi_cap, last_rx;

    spi_reg_master #(
      .FRAME_BITS (N),
      .CLK_DIV    (H)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .tx_data  (tx_data),
      .busy     (busy),
      .done     (done),
      .rx_data  (rx_data),
      .spi_cs_n (cs_n),
      .spi_clk  (sclk),
      .spi_mosi (mosi),
      .spi_miso (miso)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      check($sformatf("N%0d/H%0d %s", N, H, nm), act, exp);
    endtask

    // Called at #1 after a rising edge; returns in the first cycle with busy low.
    task automatic wait_idle();
      int unsigned n = 0;
      while (busy !== 1'b0 && n < TMO) begin
        @(posedge clk); #1;
        n++;
      end
      chk("idle_within_bound", 64'(busy === 1'b0), 64'd1);
    endtask

    task automatic send(input logic [31:0] tx, input logic [31:0] pat);
      exp_t e;
      wait_idle();
      start   = 1'b1;
      tx_data = N'(tx);
      e.tx = tx; e.pat = pat; e.acc = cyc; e.b2b = 1'b0;
      q.push_back(e);
      @(posedge clk); #1;
      start   = 1'b0;
      tx_data = N'($urandom);
    endtask

    // Stimulus.
    initial begin
      exp_t        e;
      int unsigned n, t;
      rst_n = 1'b0; start = 1'b0; tx_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_cs_n", 64'(cs_n), 64'd1);
      chk("reset_sclk", 64'(sclk), 64'd0);
      chk("reset_mosi", 64'(mosi), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_rx_data", 64'(rx_data), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NDIR; i++) begin
        logic [31:0] tv;
        tv = (N == 16) ? D16[i] : $urandom;
        send(tv, (N == 32) ? 32'hA5A5_5A5A : tv);
      end

      for (int i = 0; i < NBUSY; i++) begin
        send((N == 16) ? 32'h1234 : $urandom, $urandom);
        repeat (BOFF - 1) begin @(posedge clk); #1; end
        chk("busy_at_ignored_start", 64'(busy), 64'd1);
        start = 1'b1; tx_data = '1;
        @(posedge clk); #1;
        start = 1'b0;
      end

      for (int i = 0; i < NRND; i++) begin
        send($urandom, $urandom);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end

      wait_idle();
      n = 0; t = 0;
      while (n < NB2B && t < 10 * TMO) begin
        start   = 1'b1;
        tx_data = N'($urandom);
        if (busy == 1'b0) begin
          e.tx = 32'(tx_data); e.pat = $urandom; e.acc = cyc; e.b2b = (n > 0);
          q.push_back(e);
          n++;
        end
        @(posedge clk); #1;
        t++;
      end
      start = 1'b0;

      // Reset while bit RB is on the wire.
      send($urandom, $urandom);
      repeat (H + 2 * RB * H) @(posedge clk);
      #2;
      chk("cs_low_before_reset", 64'(cs_n), 64'd0);
      chk("sclk_high_before_reset", 64'(sclk), 64'd1);
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("async_reset_cs_n", 64'(cs_n), 64'd1);
      chk("async_reset_sclk", 64'(sclk), 64'd0);
      chk("async_reset_busy", 64'(busy), 64'd0);
      chk("async_reset_done", 64'(done), 64'd0);
      chk("async_reset_rx_data", 64'(rx_data), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      send($urandom, $urandom);
      wait_idle();
      @(negedge clk); #1;
      chk("frames_left_in_queue", 64'(q.size()), 64'd0);
      chk("stray_sclk_edges", 64'(stray), 64'd0);
      fin = 1'b1;
    end

    // Pin monitor with a MISO responder; compares each frame when done pulses.
    always @(negedge clk) begin : mon
      exp_t        e;
      logic [31:0] p;
      if (!rst_n) begin
        p_cs = 1'b1; p_sclk = 1'b0; p_busy = 1'b0; p_mosi = 1'b0; miso = 1'b0;
        fall_cnt = 0; rise_cnt = 0; edge_err = 0; mosi_cap = '0;
        busy_exp = 1'b0; last_rx = '0;
        if (cyc < 4) begin stray = 0; cs_rise_cyc = 0; last_acc = 0; end
      end else begin
        if (!cs_n && p_cs) begin
          chk("frame_pending_at_cs_fall", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            chk("cs_fall_cycle", 64'(cyc), 64'(q[0].acc + 1));
            if (q[0].b2b) chk("b2b_cs_high_gap", 64'(cyc - cs_rise_cyc), 64'(H + 1));
          end
          chk("rx_data_held", 64'(rx_data), 64'(last_rx));
          fall_cnt = 0; rise_cnt = 0; edge_err = 0; mosi_cap = '0;
        end
        if (sclk && !p_sclk) begin
          if (cs_n) stray++;
          else if (q.size() == 0 || cyc != t_rise(q[0].acc, rise_cnt, H)) edge_err++;
          if (q.size() != 0 && rise_cnt < N) begin
            p    = q[0].pat;
            miso = p[N - 1 - rise_cnt];
          end
          rise_cnt++;
        end
        if (!sclk && p_sclk) begin
          if (cs_n) stray++;
          else if (q.size() == 0 || cyc != t_fall(q[0].acc, fall_cnt, H)) edge_err++;
          mosi_cap = {mosi_cap[30:0], mosi};
          fall_cnt++;
        end
        if (sclk && p_sclk && (mosi != p_mosi)) edge_err++;
        if (done) begin
          chk("frame_pending_at_done", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.acc + 1 + (2 * N + 1) * H));
            chk("cs_rise_with_done", 64'({cs_n, p_cs}), 64'd2);
            chk("rx_data", 64'(rx_data), 64'(e.pat & MASK));
            chk("mosi_bits", 64'(mosi_cap & MASK), 64'(e.tx & MASK));
            chk("falling_edges", 64'(fall_cnt), 64'(N));
            chk("edge_timing_errors", 64'(edge_err), 64'd0);
            last_rx  = e.pat & MASK;
            last_acc = e.acc;
            busy_exp = 1'b1;
          end
        end
        if (cs_n && !p_cs) cs_rise_cyc = cyc;
        if (!busy && p_busy) begin
          chk("busy_fall_after_done", 64'(busy_exp), 64'd1);
          chk("busy_fall_cycle", 64'(cyc), 64'(last_acc + 1 + (2 * N + 2) * H));
          chk("idle_mosi_low", 64'(mosi), 64'd0);
          busy_exp = 1'b0;
        end
        p_cs = cs_n; p_sclk = sclk; p_busy = busy; p_mosi = mosi;
      end
    end
  end

  // Completion and summary.
  initial begin
    int unsigned t = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && t < 90000) begin
      @(posedge clk);
      t++;
    end
    check("all_configs_finished", 64'(cfg[0].fin && cfg[1].fin && cfg[2].fin), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
